// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GNT_CPU = 2'b01,
    GNT_IO  = 2'b10
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_IO  = 1'b1;

  localparam int unsigned DEFAULT_MAX_WAIT = 4;
  localparam int unsigned WAIT_W           = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive denied IO cycles; clear wins over increment.
module starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  output logic [WAIT_W-1:0] count,
  output logic              limit_hit
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

  assign limit_hit = (count == LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !limit_hit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-way registered arbiter for a single-port synchronous RAM: CPU priority,
// IO anti-starvation, one access per cycle, read data steered back with a strobe.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, next_state;
  logic              m_cpu, m_io;
  logic              wait_inc, wait_clr, limit_hit;
  logic [WAIT_W-1:0] wait_cnt;
  logic              rd_pend, rd_owner;
  logic [DATA_W-1:0] cpu_rdata_q, io_rdata_q;

  assign cpu_gnt = (state == GNT_CPU);
  assign io_gnt  = (state == GNT_IO);

  // A requester is ignored during its own grant cycle.
  assign m_cpu = cpu_req & ~cpu_gnt;
  assign m_io  = io_req  & ~io_gnt;

  always_comb begin
    next_state = IDLE;
    if (m_io && limit_hit) begin
      next_state = GNT_IO;
    end else if (m_cpu) begin
      next_state = GNT_CPU;
    end else if (m_io) begin
      next_state = GNT_IO;
    end
    wait_clr = !io_req || (next_state == GNT_IO);
    wait_inc = m_io && (next_state != GNT_IO);
  end

  starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk       (clk),
    .reset     (reset),
    .inc       (wait_inc),
    .clr       (wait_clr),
    .count     (wait_cnt),
    .limit_hit (limit_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      state <= next_state;
      unique case (next_state)
        GNT_CPU: begin
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
          mem_we    <= cpu_we;
        end
        GNT_IO: begin
          mem_addr  <= io_addr;
          mem_wdata <= io_wdata;
          mem_we    <= io_we;
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

  // RAM data appears the cycle after the grant; the strobe is registered and
  // the data passes through, with a holding copy for the idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend     <= 1'b0;
      rd_owner    <= OWN_CPU;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
    end else begin
      rd_pend  <= (cpu_gnt || io_gnt) && !mem_we;
      rd_owner <= io_gnt ? OWN_IO : OWN_CPU;
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (io_rvalid)  io_rdata_q  <= mem_rdata;
    end
  end

  assign cpu_rvalid = rd_pend && (rd_owner == OWN_CPU);
  assign io_rvalid  = rd_pend && (rd_owner == OWN_IO);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign io_rdata   = io_rvalid  ? mem_rdata : io_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed vector table, corner sequences, random vs. cycle model.
module tb_mem_port_arbiter;

  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic        io_req = 1'b0, io_we = 1'b0;
  logic [15:0] io_addr = '0, io_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, io_gnt, io_rvalid, mem_we;
  logic [15:0] cpu_rdata, io_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;

  logic [15:0] ram [256] = '{default: 16'h0000};

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM: data for the presented address one cycle later.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic cr, cw; logic [15:0] ca, cd;
    logic ir, iw; logic [15:0] ia, id;
    logic gc, gi, we; logic [15:0] addr, wd;
    logic rc, ri; logic [15:0] rdc, rdi;
  } vec_t;

  function automatic vec_t mk(
    input logic cr, cw, input logic [15:0] ca, cd,
    input logic ir, iw, input logic [15:0] ia, id,
    input logic gc, gi, we, input logic [15:0] addr, wd,
    input logic rc, ri, input logic [15:0] rdc, rdi);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.ir = ir; v.iw = iw; v.ia = ia; v.id = id;
    v.gc = gc; v.gi = gi; v.we = we; v.addr = addr; v.wd = wd;
    v.rc = rc; v.ri = ri; v.rdc = rdc; v.rdi = rdi;
    return v;
  endfunction

  task automatic drive(input logic cr, cw, input logic [15:0] ca, cd,
                       input logic ir, iw, input logic [15:0] ia, id);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    io_req = ir; io_we = iw; io_addr = ia; io_wdata = id;
  endtask

  vec_t vecs [20];

  // Reference model state for the random phase
  logic        e_cg, e_ig, e_we, e_crv, e_irv;
  logic [15:0] e_addr, e_wd, e_crd, e_ird;
  int          wcnt;
  logic [15:0] shadow [256];

  initial begin
    vecs[0]  = mk(0,0,16'h0,16'h0,      1,1,16'h10,16'hBEEF,  0,1,1,16'h10,16'hBEEF,  0,0,16'h0,16'h0);
    vecs[1]  = mk(1,1,16'h20,16'hAAAA,  0,0,16'h0,16'h0,      1,0,1,16'h20,16'hAAAA,  0,0,16'h0,16'h0);
    vecs[2]  = mk(0,0,16'h0,16'h0,      1,1,16'h30,16'h5555,  0,1,1,16'h30,16'h5555,  0,0,16'h0,16'h0);
    vecs[3]  = mk(1,1,16'h40,16'h4444,  0,0,16'h0,16'h0,      1,0,1,16'h40,16'h4444,  0,0,16'h0,16'h0);
    vecs[4]  = mk(0,0,16'h0,16'h0,      1,1,16'h50,16'h5050,  0,1,1,16'h50,16'h5050,  0,0,16'h0,16'h0);
    vecs[5]  = mk(1,0,16'h10,16'h0,     0,0,16'h0,16'h0,      1,0,0,16'h10,16'h0,     0,0,16'h0,16'h0);
    vecs[6]  = mk(0,0,16'h0,16'h0,      0,0,16'h0,16'h0,      0,0,0,16'h0,16'h0,      1,0,16'hBEEF,16'h0);
    vecs[7]  = mk(0,0,16'h0,16'h0,      0,0,16'h0,16'h0,      0,0,0,16'h0,16'h0,      0,0,16'h0,16'h0);
    vecs[8]  = mk(0,0,16'h0,16'h0,      1,1,16'h200,16'h1234, 0,1,1,16'h200,16'h1234, 0,0,16'h0,16'h0);
    vecs[9]  = mk(0,0,16'h0,16'h0,      0,0,16'h0,16'h0,      0,0,0,16'h0,16'h0,      0,0,16'h0,16'h0);
    vecs[10] = mk(1,0,16'h20,16'h0,     1,0,16'h30,16'h0,     1,0,0,16'h20,16'h0,     0,0,16'h0,16'h0);
    vecs[11] = mk(0,0,16'h0,16'h0,      1,0,16'h30,16'h0,     0,1,0,16'h30,16'h0,     1,0,16'hAAAA,16'h0);
    vecs[12] = mk(0,0,16'h0,16'h0,      0,0,16'h0,16'h0,      0,0,0,16'h0,16'h0,      0,1,16'h0,16'h5555);
    vecs[13] = mk(0,0,16'h0,16'h0,      0,0,16'h0,16'h0,      0,0,0,16'h0,16'h0,      0,0,16'h0,16'h0);
    vecs[14] = mk(1,0,16'h40,16'h0,     1,0,16'h50,16'h0,     1,0,0,16'h40,16'h0,     0,0,16'h0,16'h0);
    vecs[15] = mk(1,0,16'h40,16'h0,     1,0,16'h50,16'h0,     0,1,0,16'h50,16'h0,     1,0,16'h4444,16'h0);
    vecs[16] = mk(1,0,16'h40,16'h0,     1,0,16'h50,16'h0,     1,0,0,16'h40,16'h0,     0,1,16'h0,16'h5050);
    vecs[17] = mk(1,0,16'h40,16'h0,     1,0,16'h50,16'h0,     0,1,0,16'h50,16'h0,     1,0,16'h4444,16'h0);
    vecs[18] = mk(0,0,16'h0,16'h0,      0,0,16'h0,16'h0,      0,0,0,16'h0,16'h0,      0,1,16'h0,16'h5050);
    vecs[19] = mk(0,0,16'h0,16'h0,      0,0,16'h0,16'h0,      0,0,0,16'h0,16'h0,      0,0,16'h0,16'h0);

    // Reset release with idle inputs
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("idle%0d strobes", c),
            32'({cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, mem_we}), 32'h0);
      check($sformatf("idle%0d mem_addr", c), 32'(mem_addr), 32'h0);
    end

    // Directed vector table: one row per cycle, outputs checked after the edge
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
            vecs[i].ir, vecs[i].iw, vecs[i].ia, vecs[i].id);
      @(negedge clk);
      check($sformatf("row%0d cpu_gnt", i), 32'(cpu_gnt), 32'(vecs[i].gc));
      check($sformatf("row%0d io_gnt", i), 32'(io_gnt), 32'(vecs[i].gi));
      check($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(vecs[i].we));
      check($sformatf("row%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].rc));
      check($sformatf("row%0d io_rvalid", i), 32'(io_rvalid), 32'(vecs[i].ri));
      if (vecs[i].gc || vecs[i].gi) check($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
      if (vecs[i].we) check($sformatf("row%0d mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].wd));
      if (vecs[i].rc) check($sformatf("row%0d cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].rdc));
      if (vecs[i].ri) check($sformatf("row%0d io_rdata", i), 32'(io_rdata), 32'(vecs[i].rdi));
    end

    // Both requests held: IO must be served within 6 cycles
    begin
      bit seen = 1'b0;
      drive(1, 0, 16'h10, 16'h0, 1, 0, 16'h20, 16'h0);
      for (int c = 0; c < 6 && !seen; c++) begin
        @(negedge clk);
        if (io_gnt) seen = 1'b1;
      end
      check("starve io_gnt within 6", 32'(seen), 32'h1);
      check("starve wait_cnt after gnt", 32'(dut.wait_cnt), 32'h0);
      drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
      repeat (3) @(negedge clk);
    end

    // IO request withdrawn before its grant
    drive(1, 0, 16'h10, 16'h0, 1, 0, 16'h20, 16'h0);
    @(negedge clk);
    check("wd cpu_gnt", 32'(cpu_gnt), 32'h1);
    check("wd io_gnt denied", 32'(io_gnt), 32'h0);
    check("wd wait_cnt counted", 32'(dut.wait_cnt), 32'h1);
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    check("wd io_gnt after drop", 32'(io_gnt), 32'h0);
    check("wd wait_cnt cleared", 32'(dut.wait_cnt), 32'h0);
    @(negedge clk);
    check("wd io_gnt later", 32'(io_gnt), 32'h0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a read
    drive(1, 0, 16'h10, 16'h0, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    check("mr cpu_gnt", 32'(cpu_gnt), 32'h1);
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    reset = 1'b0;
    #1;
    check("mr reset strobes", 32'({cpu_gnt, io_gnt, mem_we}), 32'h0);
    check("mr reset mem_addr", 32'(mem_addr), 32'h0);
    check("mr reset mem_wdata", 32'(mem_wdata), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("mr no rvalid %0d", c), 32'({cpu_rvalid, io_rvalid}), 32'h0);
    end

    // Random traffic against a cycle-level model of the arbitration rules
    e_cg = 0; e_ig = 0; e_we = 0; e_crv = 0; e_irv = 0;
    e_addr = '0; e_wd = '0; e_crd = '0; e_ird = '0; wcnt = 0;
    for (int a = 0; a < 256; a++) shadow[a] = ram[a];
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic n_crv, n_irv, m_c, m_i;
      int win;
      check("rnd cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
      check("rnd io_gnt", 32'(io_gnt), 32'(e_ig));
      check("rnd mem_we", 32'(mem_we), 32'(e_we));
      check("rnd mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_we) check("rnd mem_wdata", 32'(mem_wdata), 32'(e_wd));
      check("rnd cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
      check("rnd io_rvalid", 32'(io_rvalid), 32'(e_irv));
      check("rnd cpu_rdata", 32'(cpu_rdata), 32'(e_crd));
      check("rnd io_rdata", 32'(io_rdata), 32'(e_ird));
      check("rnd wait_cnt", 32'(dut.wait_cnt), 32'(wcnt));

      // Protocol-legal stimulus: fields stay put while a request waits
      if (cpu_req && !e_cg) begin
        if ($urandom_range(15) == 0) cpu_req = 1'b0;
      end else begin
        cpu_req = 1'($urandom_range(1)); cpu_we = 1'($urandom_range(1));
        cpu_addr = {8'($urandom), 1'b1, 7'($urandom)}; cpu_wdata = 16'($urandom);
      end
      if (io_req && !e_ig) begin
        if ($urandom_range(15) == 0) io_req = 1'b0;
      end else begin
        io_req = 1'($urandom_range(1)); io_we = 1'($urandom_range(1));
        io_addr = {8'($urandom), 1'b1, 7'($urandom)}; io_wdata = 16'($urandom);
      end

      // A read granted this cycle returns shadow contents next cycle
      n_crv = e_cg && !e_we;
      n_irv = e_ig && !e_we;
      if (n_crv) e_crd = shadow[e_addr[7:0]];
      if (n_irv) e_ird = shadow[e_addr[7:0]];
      if (e_we) shadow[e_addr[7:0]] = e_wd;
      e_crv = n_crv; e_irv = n_irv;

      m_c = cpu_req && !e_cg;
      m_i = io_req && !e_ig;
      if (m_i && wcnt == int'(MAX_WAIT)) win = 2;
      else if (m_c) win = 1;
      else if (m_i) win = 2;
      else win = 0;
      if (!io_req || win == 2) wcnt = 0;
      else if (m_i && wcnt < int'(MAX_WAIT)) wcnt = wcnt + 1;

      e_cg = (win == 1);
      e_ig = (win == 2);
      if (win == 1) begin e_addr = cpu_addr; e_wd = cpu_wdata; e_we = cpu_we; end
      else if (win == 2) begin e_addr = io_addr; e_wd = io_wdata; e_we = io_we; end
      else e_we = 1'b0;

      @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port synchronous data/instruction memory between the multicycle CPU controller/datapath (fetch, LB, SB) and a secondary IO/display requester.
- Registered two-way arbitration: CPU priority, plus an anti-starvation guarantee for the IO port.
- Drives the memory address, write-data and write-enable lines, and routes read data back with a valid strobe.
- Sits between the CPU datapath memory mux and the block RAM.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
MAX_WAIT, 4, consecutive denied IO-request cycles after which IO beats CPU (1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request; held with stable addr/we/wdata until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  one-cycle pulse: CPU access on memory this cycle
cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
cpu_rdata  out  DATA_W  read data to CPU
io_req, io_we, io_addr, io_wdata  in  1/1/ADDR_W/DATA_W  same meaning, IO requester
io_gnt, io_rvalid  out  1  same meaning, IO requester
io_rdata  out  DATA_W  read data to IO
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write enable
mem_rdata  in  DATA_W  memory read data; valid one cycle after address is presented

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE, wait_cnt = 0, no pending read.
  - All gnt/rvalid/mem_we = 0; mem_addr = 0; mem_wdata = 0.
  - A read in flight at reset is dropped: no rvalid after release.
- States: IDLE, GNT_CPU, GNT_IO. Next state is decided every cycle from masked requests:
  - m_cpu = cpu_req & ~cpu_gnt; m_io = io_req & ~io_gnt. A requester's req is ignored in its own grant cycle.
  - m_io & (wait_cnt == MAX_WAIT) -> GNT_IO
  - else m_cpu -> GNT_CPU
  - else m_io -> GNT_IO
  - else -> IDLE
- In GNT_x:
  - gnt_x = 1 for exactly one cycle.
  - mem_addr/mem_wdata/mem_we are registered copies of x's inputs captured at the decision edge.
  - mem_we = x_we; mem_we is never 1 outside a grant state.
- Latency:
  - Request sampled at edge N -> gnt at N+1 -> (read) x_rvalid = 1 and x_rdata = mem_rdata at N+2.
  - x_rdata holds its last value when rvalid = 0. Writes produce no rvalid.
- Throughput:
  - One memory access per cycle overall.
  - A single requester gets at most one grant every 2 cycles.
  - CPU and IO may alternate back-to-back grants.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle m_io = 1 and the next state is not GNT_IO.
  - Cleared when GNT_IO is entered or when io_req = 0.
- Simultaneous events:
  - A read rvalid to one requester may coincide with the other requester's gnt; both are valid.
  - Both reqs in IDLE with wait_cnt < MAX_WAIT -> CPU wins.
- Protocol:
  - Dropping req before gnt withdraws the request; no gnt is issued.
  - Changing addr/we/wdata while req = 1 and before gnt is a protocol violation; the captured value is whatever was present at the decision edge.

Decomposition:
- Shared package: state encodings IDLE = 2'b00, GNT_CPU = 2'b01, GNT_IO = 2'b10; owner IDs OWN_CPU = 0, OWN_IO = 1; default MAX_WAIT.
- One sub-module, starve_counter: saturating counter with inc/clr/limit-hit, parameterised by MAX_WAIT.
- Arbitration FSM, request capture and read-return steering stay in mem_port_arbiter.

Test Plan:
- Reset release, no reqs for 5 cycles -> all gnt/rvalid/mem_we = 0, mem_addr = 0; mid-read reset -> no rvalid after release.
- CPU read addr 0x0010, mem returns 0xBEEF -> cpu_gnt at N+1 with mem_addr = 0x0010, mem_we = 0; cpu_rvalid = 1, cpu_rdata = 0xBEEF at N+2.
- IO write addr 0x0200 data 0x1234 -> io_gnt at N+1, mem_we = 1, mem_wdata = 0x1234 for one cycle; no io_rvalid.
- Both req at N, wait_cnt = 0 -> cpu_gnt at N+1, io_gnt at N+2; accesses alternate.
- CPU req constant, io_req constant, MAX_WAIT = 4 -> io_gnt within 6 cycles of io_req; wait_cnt returns to 0 after the grant.
- io_req dropped before gnt -> no io_gnt; wait_cnt cleared to 0.
